// File: rtl/rocketcpu_wb_bridge_pkg.sv
// Shared constants, state encoding and response formatting for the byte-stream Wishbone bridge.
package rocketcpu_wb_bridge_pkg;

  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;

  localparam logic [7:0] RSP_WOK   = 8'hA5;
  localparam logic [7:0] RSP_ROK   = 8'h5A;
  localparam logic [7:0] RSP_TMO   = 8'hEE;
  localparam logic [7:0] RSP_BADOP = 8'hE1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_BUS  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    RES_WOK = 2'd0,
    RES_ROK = 2'd1,
    RES_TMO = 2'd2,
    RES_BAD = 2'd3
  } res_t;

  // Response bytes packed first-byte-lowest, as the shifter sends them.
  function automatic logic [39:0] rsp_bytes(res_t r, logic [31:0] rdt);
    logic [39:0] b;
    case (r)
      RES_ROK: b = {rdt, RSP_ROK};
      RES_TMO: b = {32'h0, RSP_TMO};
      RES_BAD: b = {32'h0, RSP_BADOP};
      default: b = {32'h0, RSP_WOK};
    endcase
    return b;
  endfunction

  function automatic logic [2:0] rsp_len(res_t r);
    return (r == RES_ROK) ? 3'd5 : 3'd1;
  endfunction

endpackage

// File: rtl/rocketcpu_wb_bridge_if.sv
// Byte-stream and Wishbone signals of the debug bridge, grouped for the bridge (master) and its environment (slave).
interface rocketcpu_wb_bridge_if;
  // RX is a one-cycle strobe with no backpressure; TX holds o_tx_data/o_tx_valid until o_tx_valid && i_tx_ready
  // is seen on a rising edge; a Wishbone cycle holds o_wb_cyc and its fields stable until a one-cycle i_wb_ack.
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_wb_rdt, i_wb_ack,
    output o_tx_data, o_tx_valid, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_ready, i_wb_rdt, i_wb_ack,
    input  o_tx_data, o_tx_valid, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc
  );
endinterface

// File: rtl/rocketcpu_wb_bridge_tx.sv
// Response shifter: loads up to five bytes and presents them one at a time under valid/ready.
module rocketcpu_wb_bridge_tx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [39:0] load_data,
  input  logic [2:0]  load_len,
  input  logic        ready,
  output logic [7:0]  data,
  output logic        valid,
  output logic        busy
);

  logic [39:0] shreg;
  logic [2:0]  len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      len   <= '0;
    end else if (load) begin
      shreg <= load_data;
      len   <= load_len;
    end else if (valid && ready) begin
      shreg <= {8'h00, shreg[39:8]};
      len   <= len - 3'd1;
    end
  end

  assign data  = shreg[7:0];
  assign valid = (len != 3'd0);
  assign busy  = valid;

endmodule

// File: rtl/rocketcpu_wb_bridge.sv
// Debug Wishbone initiator: parses write/read commands from a byte stream, runs one bus cycle, returns status bytes.
module rocketcpu_wb_bridge
  import rocketcpu_wb_bridge_pkg::*;
#(
  parameter int TIMEOUT      = 1024,
  parameter int IDLE_TIMEOUT = 120000
) (
  input  logic                   i_wb_clk,
  input  logic                   reset_n,
  rocketcpu_wb_bridge_if.master  bus,
  output logic                   o_busy,
  output state_t                 state_dbg
);

  localparam int BW = $clog2(TIMEOUT + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BW-1:0] TMO_LAST  = BW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BUS_ONE   = BW'(1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_ONE  = IW'(1);

  state_t        state, state_nxt;
  logic [1:0]    cnt;
  logic [IW-1:0] idle_cnt;
  logic [BW-1:0] bus_cnt;
  logic [31:0]   adr, dat, rdt;
  logic [3:0]    sel;
  logic          we;
  res_t          res;
  logic          tx_load, tx_busy;
  logic [39:0]   rsp_data;
  logic [2:0]    rsp_n;
  logic          rx_take, idle_expired, opcode_ok;

  assign rx_take      = bus.i_rx_valid && (state == ST_ADDR || state == ST_DATA);
  assign idle_expired = !bus.i_rx_valid && (idle_cnt == IDLE_LAST);
  assign opcode_ok    = (bus.i_rx_data[7:4] == OP_WRITE) || (bus.i_rx_data[7:4] == OP_READ);

  always_comb begin
    state_nxt = state;
    tx_load   = 1'b0;
    case (state)
      ST_IDLE: if (bus.i_rx_valid) state_nxt = opcode_ok ? ST_ADDR : ST_RESP;
      ST_ADDR: begin
        if (bus.i_rx_valid && cnt == 2'd3) state_nxt = we ? ST_DATA : ST_BUS;
        else if (idle_expired)             state_nxt = ST_IDLE;
      end
      ST_DATA: begin
        if (bus.i_rx_valid && cnt == 2'd3) state_nxt = ST_BUS;
        else if (idle_expired)             state_nxt = ST_IDLE;
      end
      ST_BUS:  if (bus.i_wb_ack || bus_cnt == TMO_LAST) state_nxt = ST_RESP;
      // cnt==0 marks the first RESP cycle, which loads the shifter; bad opcodes also drain through here.
      ST_RESP: begin
        if (cnt == 2'd0) tx_load = 1'b1;
        else if (!tx_busy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_wb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idle_cnt <= '0;
      bus_cnt  <= '0;
      adr      <= '0;
      dat      <= '0;
      rdt      <= '0;
      sel      <= '0;
      we       <= 1'b0;
      res      <= RES_WOK;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt      <= '0;
        idle_cnt <= '0;
        bus_cnt  <= '0;
      end else begin
        if (rx_take)             cnt <= cnt + 2'd1;
        if (state == ST_RESP)    cnt <= 2'd1;
        if (rx_take)             idle_cnt <= '0;
        else if (state == ST_ADDR || state == ST_DATA) idle_cnt <= idle_cnt + IDLE_ONE;
        if (state == ST_BUS)     bus_cnt <= bus_cnt + BUS_ONE;
      end
      case (state)
        ST_IDLE: if (bus.i_rx_valid) begin
          we  <= (bus.i_rx_data[7:4] == OP_WRITE);
          sel <= (bus.i_rx_data[7:4] == OP_WRITE) ? bus.i_rx_data[3:0] : 4'hF;
          if (!opcode_ok) res <= RES_BAD;
        end
        ST_ADDR: if (bus.i_rx_valid) adr[{cnt, 3'b000} +: 8] <= bus.i_rx_data;
        ST_DATA: if (bus.i_rx_valid) dat[{cnt, 3'b000} +: 8] <= bus.i_rx_data;
        ST_BUS: begin
          // An ack on the final timeout cycle still wins.
          if (bus.i_wb_ack) begin
            rdt <= bus.i_wb_rdt;
            res <= we ? RES_WOK : RES_ROK;
          end else if (bus_cnt == TMO_LAST) begin
            res <= RES_TMO;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_data = rsp_bytes(res, rdt);
  assign rsp_n    = rsp_len(res);

  rocketcpu_wb_bridge_tx u_tx (
    .clk       (i_wb_clk),
    .rst_n     (reset_n),
    .load      (tx_load),
    .load_data (rsp_data),
    .load_len  (rsp_n),
    .ready     (bus.i_tx_ready),
    .data      (bus.o_tx_data),
    .valid     (bus.o_tx_valid),
    .busy      (tx_busy)
  );

  assign bus.o_wb_cyc = (state == ST_BUS);
  assign bus.o_wb_adr = adr;
  assign bus.o_wb_dat = dat;
  assign bus.o_wb_sel = sel;
  assign bus.o_wb_we  = we;
  assign o_busy       = (state != ST_IDLE);
  assign state_dbg    = state;

endmodule
